countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Counts down from a loaded M:SS.d value to 0:00.0 in tenth-of-second steps.
//  Uses the same BCD digit format as Stopwatch (minutes, sec_high, sec_low, tenths).
//  Raises a one-cycle done pulse and a sticky expired flag at zero.
//  Drives the same display path as Stopwatch; the top level selects between them.
// PARAMETERS
//  TICKS_PER_TENTH  10_000_000  clock cycles per 0.1 s at 100 MHz (benches use 5)
// PORTS
//  clock         in   1  system clock, 100 MHz
//  reset         in   1  synchronous, active-high; highest priority
//  load          in   1  one-cycle strobe; captures load_* digits
//  start         in   1  level: 1 = count down, 0 = hold
//  load_min      in   4  BCD preset, minutes 0-9
//  load_sec_high in   4  BCD preset, tens of seconds 0-5
//  load_sec_low  in   4  BCD preset, seconds 0-9
//  load_tenths   in   4  BCD preset, tenths 0-9
//  minutes       out  4  current value, registered
//  sec_high      out  4
//  sec_low       out  4
//  tenths        out  4
//  running       out  1  1 while in RUN
//  expired       out  1  sticky; 1 in EXPIRED
//  done          out  1  one-cycle pulse on reaching zero
// BEHAVIOUR
//  Reset: all digits 0, prescaler 0, state IDLE; running, expired and done all 0.
//  Priority: reset > load > start.
//  States:
//   IDLE: after reset or load. Prescaler held at 0.
//     start=1 with a nonzero value -> RUN.
//     start=1 with value 0:00.0 -> EXPIRED, done=1 on that cycle.
//   RUN: prescaler counts 0..TICKS_PER_TENTH-1 and wraps.
//     The edge with prescaler==TICKS_PER_TENTH-1 is a tick; first tick comes
//     TICKS_PER_TENTH cycles after entering RUN.
//     start=0 -> PAUSE.
//   PAUSE: digits and prescaler frozen; start=1 -> RUN and the prescaler resumes.
//   EXPIRED: digits stay 0:00.0; start ignored. Exits only by load or reset.
//  Load (any state): capture digits; clamp minutes/sec_low/tenths >9 to 9 and
//   sec_high >5 to 5. Prescaler cleared, state -> IDLE, expired cleared, done=0.
//  Tick arithmetic, BCD borrow chain:
//   tenths 0->9 borrows from sec_low; sec_low 0->9 borrows from sec_high;
//   sec_high 0->5 borrows from minutes. Minutes never underflow.
//   A tick from 0:00.1 sets 0:00.0, done=1 for that cycle, expired=1, -> EXPIRED.
//   Digits update on the tick edge itself; no extra latency.
//  Load and tick on the same cycle: load wins, tick discarded.
//  Reset mid-RUN: returns to the reset state on the next edge.
//  done is never asserted on two consecutive cycles.
// STRUCTURE
//  timer_pkg (shared with Stopwatch):
//   state encodings IDLE/RUN/PAUSE/EXPIRED; digit limits MAX_DIGIT=9, MAX_SEC_HIGH=5.
//  Sub-module bcd_down_digit, parameter MAX:
//   inputs dec_in, load, load_val; outputs digit, borrow_out.
//   Instantiated 4x as a ripple chain.
//  Parent holds the FSM, the prescaler, and the zero-detect / done logic.
// TESTING (TICKS_PER_TENTH=5)
//  1. Reset held 2 cycles -> digits 0:00.0; running=0, expired=0, done=0.
//  2. Load 1:00.0, start=1 -> 0:59.9 after exactly 5 cycles (full borrow chain).
//  3. Load 0:00.2, start=1 -> 0:00.1 at cycle 5; 0:00.0 at cycle 10 with done
//     for 1 cycle; expired=1; digits unchanged for 20 more cycles.
//  4. Load 0:01.0, run 7 cycles (0:00.9), start=0 for 20 cycles -> frozen;
//     start=1 -> 0:00.8 exactly 3 cycles later.
//  5. Load min=12, sec_high=7, sec_low=3, tenths=4 -> 9:53.4 shown.
//     Load on a tick cycle -> loaded value shown, IDLE, prescaler 0.
//  6. Load 0:00.0, start=1 -> done on the next edge, expired=1.
//     Reset during RUN -> reset state, then resumes on a fresh load.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding, BCD digit limits
// and the preset clamp helper.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [3:0] MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_SEC_HIGH = 4'd5;

    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control, preset and display signals between a controller and the countdown timer.
interface countdown_timer_if;
    logic       load;
    logic       start;
    logic [3:0] load_min;
    logic [3:0] load_sec_high;
    logic [3:0] load_sec_low;
    logic [3:0] load_tenths;
    logic [3:0] minutes;
    logic [3:0] sec_high;
    logic [3:0] sec_low;
    logic [3:0] tenths;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, start, load_min, load_sec_high, load_sec_low, load_tenths,
        input  minutes, sec_high, sec_low, tenths, running, expired, done
    );

    modport slave (
        input  load, start, load_min, load_sec_high, load_sec_low, load_tenths,
        output minutes, sec_high, sec_low, tenths, running, expired, done
    );
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with clamped preset; borrows to the next digit when
// decremented from zero, at which point it wraps to MAX.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [3:0] MAX = MAX_DIGIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            digit_reg <= 4'd0;
        end else if (load) begin
            digit_reg <= clamp_digit(load_val, MAX);
        end else if (dec_in) begin
            digit_reg <= (digit_reg == 4'd0) ? MAX : digit_reg - 4'd1;
        end
    end

    assign digit      = digit_reg;
    assign borrow_out = dec_in && (digit_reg == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// M:SS.d countdown timer: prescaler, run/pause/expire FSM and a four-digit BCD
// borrow chain, with a one-cycle done pulse when the count reaches zero.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_TENTH = 10_000_000
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam int PW = (TICKS_PER_TENTH > 1) ? $clog2(TICKS_PER_TENTH) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_TENTH - 1);

    timer_state_t  state_reg, state_next;
    logic [PW-1:0] presc_reg;
    logic          done_reg, done_next;

    logic [3:0] load_vals [4];
    logic [3:0] digits    [4];
    logic [4:0] borrow;
    logic       unused_borrow;

    logic counting, tick, value_zero, value_last;

    // Index 0 is tenths, 3 is minutes; the borrow ripples upward.
    assign load_vals[0] = bus.load_tenths;
    assign load_vals[1] = bus.load_sec_low;
    assign load_vals[2] = bus.load_sec_high;
    assign load_vals[3] = bus.load_min;

    // PAUSE with start=1 counts on its exit edge so the prescaler resumes immediately.
    assign counting = bus.start && ((state_reg == RUN) || (state_reg == PAUSE));
    assign tick     = counting && (presc_reg == PRESC_LAST) && !bus.load;

    assign value_zero = (digits[3] == 4'd0) && (digits[2] == 4'd0) &&
                        (digits[1] == 4'd0) && (digits[0] == 4'd0);
    assign value_last = (digits[3] == 4'd0) && (digits[2] == 4'd0) &&
                        (digits[1] == 4'd0) && (digits[0] == 4'd1);

    assign borrow[0]     = tick;
    assign unused_borrow = borrow[4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 2) ? MAX_SEC_HIGH : MAX_DIGIT;
            bcd_down_digit #(.MAX(LIM)) u_digit (
                .clock      (clock),
                .reset      (reset),
                .dec_in     (borrow[gi]),
                .load       (bus.load),
                .load_val   (load_vals[gi]),
                .digit      (digits[gi]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (bus.load) begin
            presc_reg <= '0;
        end else if (counting) begin
            presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
        end else if ((state_reg == IDLE) || (state_reg == EXPIRED)) begin
            presc_reg <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        if (bus.load) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_next = value_zero ? EXPIRED : RUN;
                        done_next  = value_zero;
                    end
                end
                RUN, PAUSE: begin
                    if (!bus.start) begin
                        state_next = PAUSE;
                    end else if (tick && value_last) begin
                        state_next = EXPIRED;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: state_next = EXPIRED;
            endcase
        end
    end

    always_comb begin
        bus.running  = (state_reg == RUN);
        bus.expired  = (state_reg == EXPIRED);
        bus.done     = done_reg;
        bus.tenths   = digits[0];
        bus.sec_low  = digits[1];
        bus.sec_high = digits[2];
        bus.minutes  = digits[3];
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 5-cycle tenth; every check compares the
// displayed digits or the {running, expired, done} flags with hand-derived values.
module tb_countdown_timer;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    countdown_timer_if bus ();

    countdown_timer #(.TICKS_PER_TENTH(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] shown();
        return {16'h0, bus.minutes, bus.sec_high, bus.sec_low, bus.tenths};
    endfunction

    function automatic logic [31:0] flags();
        return {29'h0, bus.running, bus.expired, bus.done};
    endfunction

    task automatic do_load(input logic [3:0] m, input logic [3:0] sh,
                           input logic [3:0] sl, input logic [3:0] t);
        bus.load_min      = m;
        bus.load_sec_high = sh;
        bus.load_sec_low  = sl;
        bus.load_tenths   = t;
        bus.load          = 1'b1;
        step(1);
        bus.load          = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.load          = 1'b0;
        bus.start         = 1'b0;
        bus.load_min      = 4'd0;
        bus.load_sec_high = 4'd0;
        bus.load_sec_low  = 4'd0;
        bus.load_tenths   = 4'd0;

        // 1. reset state
        step(2);
        check("reset_digits", shown(), 32'h0000);
        check("reset_flags",  flags(), 32'h0);
        reset = 1'b0;

        // 2. full borrow chain 1:00.0 -> 0:59.9
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        check("load_100", shown(), 32'h1000);
        bus.start = 1'b1;
        step(1);
        check("run_flags", flags(), 32'h4);
        step(4);
        check("pre_tick_100", shown(), 32'h1000);
        step(1);
        check("borrow_chain", shown(), 32'h0599);

        // 3. count to zero, done pulse, sticky expiry
        bus.start = 1'b0;
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        bus.start = 1'b1;
        step(1);
        step(5);
        check("first_tick_002", shown(), 32'h0001);
        check("no_done_yet",    flags(), 32'h4);
        step(4);
        check("hold_001", shown(), 32'h0001);
        step(1);
        check("zero_digits",  shown(), 32'h0000);
        check("zero_flags",   flags(), 32'h3);
        step(1);
        check("done_one_cycle", flags(), 32'h2);
        step(19);
        check("expired_digits", shown(), 32'h0000);
        check("expired_flags",  flags(), 32'h2);

        // 4. pause freezes digits and prescaler
        bus.start = 1'b0;
        do_load(4'd0, 4'd0, 4'd1, 4'd0);
        check("load_clears_expired", flags(), 32'h0);
        bus.start = 1'b1;
        step(1);
        step(5);
        check("tick_010", shown(), 32'h0009);
        step(2);
        bus.start = 1'b0;
        step(1);
        check("paused_flags", flags(), 32'h0);
        step(19);
        check("paused_digits", shown(), 32'h0009);
        bus.start = 1'b1;
        step(2);
        check("resume_hold", shown(), 32'h0009);
        check("resume_flags", flags(), 32'h4);
        step(1);
        check("resume_tick", shown(), 32'h0008);

        // 5. clamping, then load on a tick edge
        bus.start = 1'b0;
        do_load(4'd12, 4'd7, 4'd3, 4'd4);
        check("clamp", shown(), 32'h9534);
        bus.start = 1'b1;
        step(1);
        step(4);
        check("before_tick_edge", shown(), 32'h9534);
        do_load(4'd0, 4'd3, 4'd0, 4'd0);
        check("load_beats_tick", shown(), 32'h0300);
        check("load_beats_tick_flags", flags(), 32'h0);
        step(1);
        step(4);
        check("presc_cleared", shown(), 32'h0300);
        step(1);
        check("tick_after_reload", shown(), 32'h0299);

        // 6. start on zero, then reset mid-run
        bus.start = 1'b0;
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        bus.start = 1'b1;
        step(1);
        check("zero_start_flags",  flags(), 32'h3);
        step(1);
        check("zero_start_after",  flags(), 32'h2);
        bus.start = 1'b0;
        do_load(4'd0, 4'd0, 4'd5, 4'd0);
        bus.start = 1'b1;
        step(1);
        step(3);
        bus.start = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrun_reset_digits", shown(), 32'h0000);
        check("midrun_reset_flags",  flags(), 32'h0);
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        bus.start = 1'b1;
        step(1);
        step(5);
        check("after_reset_tick", shown(), 32'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
